// File: rtl/hazard_fwd_unit_if.sv
// Signal bundle between the pipeline control and the hazard/forwarding unit.
// master = pipeline side (issues ID info, consumes selects), slave = the unit.
interface hazard_fwd_unit_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic             hold;
  logic [RA_W-1:0]  id_ra;
  logic [RA_W-1:0]  id_rb;
  logic             id_ra_use;
  logic             id_rb_use;
  logic [RA_W-1:0]  id_rw;
  logic             id_we;
  logic             id_ld;
  logic             ex_redir;
  logic             A_MEM;
  logic             A_WB;
  logic             B_MEM;
  logic             B_WB;
  logic             stall;
  logic             bubble;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output hold, id_ra, id_rb, id_ra_use, id_rb_use, id_rw, id_we, id_ld, ex_redir,
    input  A_MEM, A_WB, B_MEM, B_WB, stall, bubble, flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  hold, id_ra, id_rb, id_ra_use, id_rb_use, id_rw, id_we, id_ld, ex_redir,
    output A_MEM, A_WB, B_MEM, B_WB, stall, bubble, flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller for a 5-stage pipeline: shadows EX/MEM/WB destination
// info, drives operand forward selects, load-use stall/bubble, redirect flush and counters.
module hazard_fwd_unit #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_fwd_unit_if.slave   bus
);

  logic [RA_W-1:0]  ex_ra;
  logic [RA_W-1:0]  ex_rb;
  logic             ex_ra_use;
  logic             ex_rb_use;
  logic [RA_W-1:0]  ex_rw;
  logic             ex_we;
  logic             ex_ld;
  logic [RA_W-1:0]  mem_rw;
  logic             mem_we;
  logic             mem_ld;
  logic [RA_W-1:0]  wb_rw;
  logic             wb_we;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic a_mem;
  logic a_wb;
  logic b_mem;
  logic b_wb;
  logic load_use;
  logic stall_c;
  logic bubble_c;
  logic flush_c;

  // Register 0 is hard-wired, so it can never be a real producer/consumer pair.
  function automatic logic match(input logic en, input logic [RA_W-1:0] src,
                                 input logic we, input logic [RA_W-1:0] rw);
    return en & we & (rw == src) & (src != '0);
  endfunction

  always_comb begin
    a_mem = match(ex_ra_use, ex_ra, mem_we, mem_rw) & ~mem_ld;
    a_wb  = match(ex_ra_use, ex_ra, wb_we, wb_rw) & ~a_mem;
    b_mem = match(ex_rb_use, ex_rb, mem_we, mem_rw) & ~mem_ld;
    b_wb  = match(ex_rb_use, ex_rb, wb_we, wb_rw) & ~b_mem;

    // Load data only becomes forwardable once the load has reached WB.
    load_use = (ex_ld  & (match(bus.id_ra_use, bus.id_ra, ex_we, ex_rw) |
                          match(bus.id_rb_use, bus.id_rb, ex_we, ex_rw))) |
               (mem_ld & (match(bus.id_ra_use, bus.id_ra, mem_we, mem_rw) |
                          match(bus.id_rb_use, bus.id_rb, mem_we, mem_rw)));

    flush_c  = bus.ex_redir;
    stall_c  = load_use & ~bus.ex_redir;
    bubble_c = load_use | bus.ex_redir;
  end

  assign bus.A_MEM     = rst_n & a_mem;
  assign bus.A_WB      = rst_n & a_wb;
  assign bus.B_MEM     = rst_n & b_mem;
  assign bus.B_WB      = rst_n & b_wb;
  assign bus.stall     = rst_n & stall_c;
  assign bus.bubble    = rst_n & bubble_c;
  assign bus.flush     = rst_n & flush_c;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ra       <= '0;
      ex_rb       <= '0;
      ex_ra_use   <= 1'b0;
      ex_rb_use   <= 1'b0;
      ex_rw       <= '0;
      ex_we       <= 1'b0;
      ex_ld       <= 1'b0;
      mem_rw      <= '0;
      mem_we      <= 1'b0;
      mem_ld      <= 1'b0;
      wb_rw       <= '0;
      wb_we       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!bus.hold) begin
      mem_rw <= ex_rw;
      mem_we <= ex_we;
      mem_ld <= ex_ld;
      wb_rw  <= mem_rw;
      wb_we  <= mem_we;
      if (bubble_c) begin
        ex_ra     <= '0;
        ex_rb     <= '0;
        ex_ra_use <= 1'b0;
        ex_rb_use <= 1'b0;
        ex_rw     <= '0;
        ex_we     <= 1'b0;
        ex_ld     <= 1'b0;
      end else begin
        ex_ra     <= bus.id_ra;
        ex_rb     <= bus.id_rb;
        ex_ra_use <= bus.id_ra_use;
        ex_rb_use <= bus.id_rb_use;
        ex_rw     <= bus.id_rw;
        ex_we     <= bus.id_we;
        ex_ld     <= bus.id_ld;
      end
      if (stall_c && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_c && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed scenarios plus random traffic,
// checked against an instruction-queue model of the forwarding/stall rules.
module tb_hazard_fwd_unit;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic [4:0] ra;
    logic [4:0] rb;
    logic       ra_use;
    logic       rb_use;
    logic [4:0] rw;
    logic       we;
    logic       ld;
  } instr_t;

  localparam instr_t NOP = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_fwd_unit_if #(.RA_W(5), .CNT_W(CW)) bus ();
  hazard_fwd_unit #(.RA_W(5), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int passes = 0;

  // Model: pl[0]=EX, pl[1]=MEM, pl[2]=WB instruction; counters as plain ints.
  instr_t pl[$];
  int     m_stall;
  int     m_flush;
  instr_t cur;
  logic   cur_redir;
  logic   cur_hold;

  function automatic instr_t mk(int ra, int rb, bit rau, bit rbu, int rw, bit we, bit ld);
    instr_t i;
    i.ra = 5'(ra); i.rb = 5'(rb); i.ra_use = rau; i.rb_use = rbu;
    i.rw = 5'(rw); i.we = we; i.ld = ld;
    return i;
  endfunction

  function automatic bit hit(logic en, logic [4:0] s, instr_t x);
    return en && x.we && (x.rw == s) && (s != 5'd0);
  endfunction

  // Returns {A_MEM, A_WB, B_MEM, B_WB, stall, bubble, flush}.
  function automatic logic [6:0] model_out(instr_t id, logic redir);
    bit am, aw, bm, bw, lu;
    am = hit(pl[0].ra_use, pl[0].ra, pl[1]) && !pl[1].ld;
    aw = hit(pl[0].ra_use, pl[0].ra, pl[2]) && !am;
    bm = hit(pl[0].rb_use, pl[0].rb, pl[1]) && !pl[1].ld;
    bw = hit(pl[0].rb_use, pl[0].rb, pl[2]) && !bm;
    lu = 1'b0;
    for (int s = 0; s < 2; s++)
      if (pl[s].ld && (hit(id.ra_use, id.ra, pl[s]) || hit(id.rb_use, id.rb, pl[s]))) lu = 1'b1;
    return {am, aw, bm, bw, lu && !redir, lu || redir, redir};
  endfunction

  function automatic logic [6:0] dut_out();
    return {bus.A_MEM, bus.A_WB, bus.B_MEM, bus.B_WB, bus.stall, bus.bubble, bus.flush};
  endfunction

  function automatic logic [2*CW-1:0] exp_cnt();
    return {CW'(m_stall), CW'(m_flush)};
  endfunction

  task automatic model_clear();
    pl = {NOP, NOP, NOP};
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic drive(instr_t i, logic redir, logic hl);
    cur = i; cur_redir = redir; cur_hold = hl;
    bus.id_ra = i.ra; bus.id_rb = i.rb; bus.id_ra_use = i.ra_use; bus.id_rb_use = i.rb_use;
    bus.id_rw = i.rw; bus.id_we = i.we; bus.id_ld = i.ld;
    bus.ex_redir = redir; bus.hold = hl;
    @(negedge clk);
  endtask

  task automatic advance();
    logic [6:0] e;
    e = model_out(cur, cur_redir);
    @(posedge clk);
    if (!cur_hold && rst_n) begin
      if (e[2] && m_stall < CNT_MAX) m_stall++;
      if (e[0] && m_flush < CNT_MAX) m_flush++;
      pl.push_front(e[1] ? NOP : cur);
      void'(pl.pop_back());
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    for (int k = 0; k < 5; k++) begin
      drive(mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
               $urandom_range(0, 3), 1'($urandom), 1'($urandom)), 1'($urandom), 1'($urandom));
      checks++;
      if (dut_out() !== 7'd0 || {bus.stall_cnt, bus.flush_cnt} !== '0)
        $display("FAIL reset_out k=%0d got=%b cnt=%h exp=0", k, dut_out(), {bus.stall_cnt, bus.flush_cnt});
      else passes++;
      advance();
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(NOP, 1'b0, 1'b0);
      checks++;
      if (dut_out() !== 7'd0 || {bus.stall_cnt, bus.flush_cnt} !== '0)
        $display("FAIL reset_idle k=%0d got=%b cnt=%h exp=0", k, dut_out(), {bus.stall_cnt, bus.flush_cnt});
      else passes++;
      advance();
    end
  endtask

  task automatic test_alu_dep();
    instr_t seq[9];
    logic [6:0] got, exp;
    seq = '{mk(0,0,0,0,3,1,0), mk(3,0,1,0,8,1,0), NOP, NOP,
            mk(0,0,0,0,3,1,0), mk(1,2,1,1,9,1,0), mk(3,0,1,0,8,1,0), NOP, NOP};
    for (int k = 0; k < 9; k++) begin
      drive(seq[k], 1'b0, 1'b0);
      got = dut_out(); exp = model_out(cur, 1'b0);
      checks++;
      if (got !== exp || {bus.stall_cnt, bus.flush_cnt} !== exp_cnt())
        $display("FAIL alu_step%0d got=%b exp=%b", k, got, exp);
      else passes++;
      if (k == 2) begin
        checks++;
        if (got[6:5] !== 2'b10) $display("FAIL alu_adjacent A_MEM/A_WB got=%b exp=10", got[6:5]);
        else passes++;
      end
      if (k == 7) begin
        checks++;
        if (got[6:5] !== 2'b01) $display("FAIL alu_dist2 A_MEM/A_WB got=%b exp=01", got[6:5]);
        else passes++;
      end
      advance();
    end
  endtask

  task automatic test_double_hit();
    instr_t seq[5];
    logic [6:0] got, exp;
    seq = '{mk(0,0,0,0,5,1,0), mk(0,0,0,0,5,1,0), mk(5,0,1,0,10,1,0), NOP, NOP};
    for (int k = 0; k < 5; k++) begin
      drive(seq[k], 1'b0, 1'b0);
      got = dut_out(); exp = model_out(cur, 1'b0);
      checks++;
      if (got !== exp) $display("FAIL dbl_step%0d got=%b exp=%b", k, got, exp);
      else passes++;
      if (k == 3) begin
        checks++;
        if (got[6:5] !== 2'b10) $display("FAIL dbl_priority A_MEM/A_WB got=%b exp=10", got[6:5]);
        else passes++;
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    instr_t seq[5];
    logic [6:0] got, exp;
    int k = 0, steps = 0, nst = 0, base;
    seq = '{mk(0,0,0,0,4,1,1), mk(1,4,0,1,11,1,0), NOP, NOP, NOP};
    base = m_stall;
    while (k < 5 && steps < 20) begin
      drive(seq[k], 1'b0, 1'b0);
      got = dut_out(); exp = model_out(cur, 1'b0);
      checks++;
      if (got !== exp || {bus.stall_cnt, bus.flush_cnt} !== exp_cnt())
        $display("FAIL ldu_step%0d got=%b exp=%b", steps, got, exp);
      else passes++;
      if (got[2]) nst++;
      if (!exp[2]) k++;
      advance();
      steps++;
    end
    checks++;
    if (nst !== 2 || int'(bus.stall_cnt) - base !== 2)
      $display("FAIL ldu_stall_cycles got=%0d cnt_delta=%0d exp=2", nst, int'(bus.stall_cnt) - base);
    else passes++;
  endtask

  task automatic test_redirect();
    instr_t seq[6];
    logic   rd[6];
    logic [6:0] got, exp;
    int fbase;
    seq = '{mk(0,0,0,0,4,1,1), mk(0,4,0,1,12,1,0), mk(0,0,0,0,0,1,1), mk(0,0,1,1,0,1,0), NOP, NOP};
    rd  = '{0, 1, 0, 0, 0, 0};
    fbase = int'(bus.flush_cnt);
    for (int k = 0; k < 6; k++) begin
      drive(seq[k], rd[k], 1'b0);
      got = dut_out(); exp = model_out(cur, rd[k]);
      checks++;
      if (got !== exp) $display("FAIL redir_step%0d got=%b exp=%b", k, got, exp);
      else passes++;
      if (k == 1) begin
        checks++;
        if (got[2:0] !== 3'b011) $display("FAIL redir_override stall/bubble/flush got=%b exp=011", got[2:0]);
        else passes++;
      end
      if (k >= 3) begin
        checks++;
        if (got[6:2] !== 5'd0) $display("FAIL r0_no_hazard k=%0d got=%b exp=00000", k, got[6:2]);
        else passes++;
      end
      advance();
    end
    checks++;
    if (int'(bus.flush_cnt) - fbase !== 1) $display("FAIL redir_flush_cnt delta got=%0d exp=1", int'(bus.flush_cnt) - fbase);
    else passes++;
  endtask

  task automatic test_hold();
    instr_t seq[4];
    logic [6:0] got, exp;
    logic [CW-1:0] snap;
    int k = 0, steps = 0, nst = 0, base;
    bit held = 0;
    seq = '{mk(0,0,0,0,6,1,1), mk(6,0,1,0,13,1,0), NOP, NOP};
    base = m_stall;
    while (k < 4 && steps < 20) begin
      drive(seq[k], 1'b0, 1'b0);
      got = dut_out(); exp = model_out(cur, 1'b0);
      checks++;
      if (got !== exp || {bus.stall_cnt, bus.flush_cnt} !== exp_cnt())
        $display("FAIL hold_step%0d got=%b exp=%b", steps, got, exp);
      else passes++;
      if (got[2]) nst++;
      if (exp[2] && !held) begin
        held = 1;
        advance();
        snap = bus.stall_cnt;
        for (int h = 0; h < 3; h++) begin
          drive(seq[k], 1'b0, 1'b1);
          checks++;
          if (bus.stall !== 1'b1 || bus.bubble !== 1'b1 || bus.stall_cnt !== snap)
            $display("FAIL hold_frozen h=%0d stall=%b cnt=%0d exp stall=1 cnt=%0d", h, bus.stall, bus.stall_cnt, snap);
          else passes++;
          advance();
        end
      end else begin
        if (!exp[2]) k++;
        advance();
      end
      steps++;
    end
    checks++;
    if (nst !== 2 || int'(bus.stall_cnt) - base !== 2)
      $display("FAIL hold_resume stalls=%0d cnt_delta=%0d exp=2", nst, int'(bus.stall_cnt) - base);
    else passes++;
  endtask

  task automatic test_reset_mid();
    drive(mk(0,0,0,0,7,1,1), 1'b0, 1'b0);
    advance();
    drive(mk(7,0,1,0,14,1,0), 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b1) $display("FAIL rstmid_pre stall got=%b exp=1", bus.stall);
    else passes++;
    #1 rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (dut_out() !== 7'd0 || {bus.stall_cnt, bus.flush_cnt} !== '0)
      $display("FAIL rstmid_async got=%b cnt=%h exp=0", dut_out(), {bus.stall_cnt, bus.flush_cnt});
    else passes++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(mk(7,0,1,0,14,1,0), 1'b0, 1'b0);
    checks++;
    if (dut_out() !== 7'd0) $display("FAIL rstmid_first_cycle got=%b exp=0000000", dut_out());
    else passes++;
    advance();
  endtask

  task automatic test_random();
    logic [6:0] got, exp;
    instr_t r;
    for (int k = 0; k < 400; k++) begin
      r = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      drive(r, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
      got = dut_out(); exp = model_out(cur, cur_redir);
      checks++;
      if (got !== exp || {bus.stall_cnt, bus.flush_cnt} !== exp_cnt())
        $display("FAIL rand_step%0d got=%b exp=%b cnt=%h exp_cnt=%h", k, got, exp,
                 {bus.stall_cnt, bus.flush_cnt}, exp_cnt());
      else passes++;
      advance();
    end
    checks++;
    if (bus.stall_cnt !== CW'(CNT_MAX)) $display("FAIL rand_stall_saturate got=%0d exp=%0d", bus.stall_cnt, CNT_MAX);
    else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout sim time exceeded");
    $fatal(1);
  end

  initial begin
    model_clear();
    cur = NOP; cur_redir = 1'b0; cur_hold = 1'b0;
    bus.hold = 1'b0; bus.id_ra = '0; bus.id_rb = '0; bus.id_ra_use = 1'b0; bus.id_rb_use = 1'b0;
    bus.id_rw = '0; bus.id_we = 1'b0; bus.id_ld = 1'b0; bus.ex_redir = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_alu_dep();
    test_double_hit();
    test_load_use();
    test_redirect();
    test_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
